// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the host command framer/deframer pair.
package uart_cmd_decoder_pkg;

  // Decoder FSM state encodings
  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CSUM    = 3'd4;

  // Default frame start marker
  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

  // Frame format: SYNC, CMD, LEN header, payload, one checksum word
  localparam int unsigned FRAME_HDR_WORDS = 3;
  localparam int unsigned FRAME_TRL_WORDS = 1;
  localparam int unsigned LEN_W           = 8;
  localparam int unsigned CSUM_W          = 8;

endpackage

// File: rtl/uart_byte_timer.sv
// Saturating inter-word gap counter; expires when a gap reaches the limit.
module uart_byte_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear on a word or when disabled, otherwise count up and saturate
  always_comb begin
    count_d = count_q;
    if (clr || !en) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A word arriving on the expiry cycle takes priority over the timeout
  assign expired_c = en && !clr && (count_q == LAST);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles SYNC/CMD/LEN/payload/checksum frames from the UART receiver into command words.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = 8,
  parameter int unsigned MAX_PAYLOAD    = 8,
  parameter logic [7:0]  SYNC_WORD      = DEFAULT_SYNC_WORD,
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WORD_SIZE-1:0]             din,
  input  logic                             din_valid,
  output logic [WORD_SIZE-1:0]             cmd_out,
  output logic [LEN_W-1:0]                 len_out,
  output logic [MAX_PAYLOAD*WORD_SIZE-1:0] payload_out,
  output logic                             cmd_valid,
  output logic                             err_checksum,
  output logic                             err_length,
  output logic                             err_timeout,
  output logic                             busy
);

  localparam int unsigned PAY_W = MAX_PAYLOAD * WORD_SIZE;

  // Working frame state
  logic [2:0]           state_q, state_d;
  logic [WORD_SIZE-1:0] cmd_q, cmd_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [WORD_SIZE-1:0] csum_q, csum_d;
  logic [WORD_SIZE-1:0] wbuf_q [MAX_PAYLOAD];
  logic [WORD_SIZE-1:0] wbuf_d [MAX_PAYLOAD];

  // Output registers
  logic [WORD_SIZE-1:0] cmd_out_q, cmd_out_d;
  logic [LEN_W-1:0]     len_out_q, len_out_d;
  logic [PAY_W-1:0]     payload_out_q, payload_out_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 err_checksum_q, err_checksum_d;
  logic                 err_length_q, err_length_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 busy_q, busy_d;

  logic tmr_en_c;
  logic tmr_expired_c;

  assign tmr_en_c = (state_q != ST_HUNT);

  uart_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (din_valid),
    .en       (tmr_en_c),
    .expired_c(tmr_expired_c)
  );

  // Frame FSM: advances on each received word; timeout drops back to HUNT
  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    len_d          = len_q;
    idx_d          = idx_q;
    csum_d         = csum_q;
    wbuf_d         = wbuf_q;
    cmd_out_d      = cmd_out_q;
    len_out_d      = len_out_q;
    payload_out_d  = payload_out_q;
    cmd_valid_d    = 1'b0;
    err_checksum_d = 1'b0;
    err_length_d   = 1'b0;
    err_timeout_d  = 1'b0;

    if (din_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (din == WORD_SIZE'(SYNC_WORD)) begin
            state_d = ST_CMD;
          end
        end
        ST_CMD: begin
          cmd_d   = din;
          csum_d  = din;
          state_d = ST_LEN;
        end
        ST_LEN: begin
          if (din > WORD_SIZE'(MAX_PAYLOAD)) begin
            err_length_d = 1'b1;
            state_d      = ST_HUNT;
          end else begin
            len_d   = LEN_W'(din);
            csum_d  = csum_q ^ din;
            idx_d   = '0;
            state_d = (din == '0) ? ST_CSUM : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          for (int i = 0; i < int'(MAX_PAYLOAD); i++) begin
            if (idx_q == LEN_W'(i)) begin
              wbuf_d[i] = din;
            end
          end
          csum_d = csum_q ^ din;
          idx_d  = idx_q + LEN_W'(1);
          if (idx_q == len_q - LEN_W'(1)) begin
            state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (din == csum_q) begin
            cmd_out_d = cmd_q;
            len_out_d = len_q;
            for (int i = 0; i < int'(MAX_PAYLOAD); i++) begin
              payload_out_d[i*WORD_SIZE +: WORD_SIZE] =
                (LEN_W'(i) < len_q) ? wbuf_q[i] : '0;
            end
            cmd_valid_d = 1'b1;
          end else begin
            err_checksum_d = 1'b1;
          end
          state_d = ST_HUNT;
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end else if (tmr_expired_c) begin
      err_timeout_d = 1'b1;
      state_d       = ST_HUNT;
    end

    busy_d = (state_d != ST_HUNT);
  end

  // State, working buffer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_HUNT;
      cmd_q          <= '0;
      len_q          <= '0;
      idx_q          <= '0;
      csum_q         <= '0;
      for (int i = 0; i < int'(MAX_PAYLOAD); i++) begin
        wbuf_q[i] <= '0;
      end
      cmd_out_q      <= '0;
      len_out_q      <= '0;
      payload_out_q  <= '0;
      cmd_valid_q    <= 1'b0;
      err_checksum_q <= 1'b0;
      err_length_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      csum_q         <= csum_d;
      wbuf_q         <= wbuf_d;
      cmd_out_q      <= cmd_out_d;
      len_out_q      <= len_out_d;
      payload_out_q  <= payload_out_d;
      cmd_valid_q    <= cmd_valid_d;
      err_checksum_q <= err_checksum_d;
      err_length_q   <= err_length_d;
      err_timeout_q  <= err_timeout_d;
      busy_q         <= busy_d;
    end
  end

  assign cmd_out      = cmd_out_q;
  assign len_out      = len_out_q;
  assign payload_out  = payload_out_q;
  assign cmd_valid    = cmd_valid_q;
  assign err_checksum = err_checksum_q;
  assign err_length   = err_length_q;
  assign err_timeout  = err_timeout_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed frames plus randomized frame mix.
module tb_uart_cmd_decoder;

  localparam int unsigned WS = 8;
  localparam int unsigned MP = 8;
  localparam int unsigned T  = 200;
  localparam int unsigned PW = MP * WS;

  localparam int EV_NONE  = 0;
  localparam int EV_VALID = 1;
  localparam int EV_CSUM  = 2;
  localparam int EV_LEN   = 3;
  localparam int EV_TMO   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [WS-1:0] din;
  logic          din_valid;
  logic [WS-1:0] cmd_out;
  logic [7:0]    len_out;
  logic [PW-1:0] payload_out;
  logic          cmd_valid;
  logic          err_checksum;
  logic          err_length;
  logic          err_timeout;
  logic          busy;

  uart_cmd_decoder #(
    .WORD_SIZE     (WS),
    .MAX_PAYLOAD   (MP),
    .SYNC_WORD     (8'hA5),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .cmd_out     (cmd_out),
    .len_out     (len_out),
    .payload_out (payload_out),
    .cmd_valid   (cmd_valid),
    .err_checksum(err_checksum),
    .err_length  (err_length),
    .err_timeout (err_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: visible output registers and expected pulse totals
  logic [7:0]    exp_cmd;
  logic [7:0]    exp_len;
  logic [PW-1:0] exp_payload;
  int exp_n_valid = 0, exp_n_csum = 0, exp_n_len = 0, exp_n_tmo = 0;
  int obs_n_valid = 0, obs_n_csum = 0, obs_n_len = 0, obs_n_tmo = 0, obs_overlap = 0;

  logic [7:0] frame_q[$];

  // Pulse monitor: totals and mutual exclusion
  always @(negedge clk) begin
    if (!rst) begin
      obs_n_valid += int'(cmd_valid);
      obs_n_csum  += int'(err_checksum);
      obs_n_len   += int'(err_length);
      obs_n_tmo   += int'(err_timeout);
      if (int'(cmd_valid) + int'(err_checksum) + int'(err_length) + int'(err_timeout) > 1)
        obs_overlap++;
    end
  end

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] w, input logic v);
    @(negedge clk);
    din       = v ? w : 8'($urandom);
    din_valid = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0);
  endtask

  function automatic int pick_gap();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return int'(T) - 1;
    if (r < 6) return 0;
    return int'($urandom_range(1, 4));
  endfunction

  task automatic send_frame(input bit gaps);
    foreach (frame_q[i]) begin
      if (i > 0 && gaps) idle(pick_gap());
      drive(frame_q[i], 1'b1);
    end
  endtask

  task automatic build_good(input logic [7:0] cmd, input int len);
    logic [7:0] cs;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(cmd);
    frame_q.push_back(8'(len));
    cs = cmd ^ 8'(len);
    for (int i = 0; i < len; i++) begin
      frame_q.push_back(8'($urandom));
      cs ^= frame_q[3 + i];
    end
    frame_q.push_back(cs);
  endtask

  task automatic check_pulses(input string tag, input int ev);
    chk({tag, "_cmd_valid"}, PW'(cmd_valid), PW'(ev == EV_VALID));
    chk({tag, "_err_csum"},  PW'(err_checksum), PW'(ev == EV_CSUM));
    chk({tag, "_err_len"},   PW'(err_length), PW'(ev == EV_LEN));
    chk({tag, "_err_tmo"},   PW'(err_timeout), PW'(ev == EV_TMO));
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_cmd_out"}, PW'(cmd_out), PW'(exp_cmd));
    chk({tag, "_len_out"}, PW'(len_out), PW'(exp_len));
    chk({tag, "_payload"}, payload_out, exp_payload);
  endtask

  // Judge the complete frame held in frame_q by the framing rules, then compare
  task automatic finish_frame(input string tag);
    int ev, len;
    logic [7:0] cs;
    idle(1);
    len = int'(frame_q[2]);
    if (len > int'(MP)) begin
      ev = EV_LEN;
      exp_n_len++;
    end else begin
      cs = frame_q[1] ^ frame_q[2];
      for (int i = 0; i < len; i++) cs ^= frame_q[3 + i];
      if (frame_q[3 + len] == cs) begin
        ev = EV_VALID;
        exp_n_valid++;
        exp_cmd     = frame_q[1];
        exp_len     = frame_q[2];
        exp_payload = '0;
        for (int i = 0; i < len; i++) exp_payload[i*8 +: 8] = frame_q[3 + i];
      end else begin
        ev = EV_CSUM;
        exp_n_csum++;
      end
    end
    check_pulses(tag, ev);
    check_outputs(tag);
    chk({tag, "_busy"}, PW'(busy), PW'(0));
  endtask

  task automatic do_timeout(input string tag);
    int k;
    build_good(8'($urandom), int'($urandom_range(0, MP)));
    k = int'($urandom_range(1, frame_q.size() - 1));
    while (frame_q.size() > k) void'(frame_q.pop_back());
    send_frame(1'b1);
    idle(int'(T));
    chk({tag, "_pre_tmo"},  PW'(err_timeout), PW'(0));
    chk({tag, "_pre_busy"}, PW'(busy), PW'(1));
    idle(1);
    exp_n_tmo++;
    check_pulses(tag, EV_TMO);
    check_outputs(tag);
    chk({tag, "_busy"}, PW'(busy), PW'(0));
  endtask

  task automatic do_junk(input string tag);
    int k;
    logic [7:0] w;
    k = int'($urandom_range(1, 4));
    for (int i = 0; i < k; i++) begin
      w = 8'($urandom);
      if (w == 8'hA5) w = 8'h00;
      idle(int'($urandom_range(0, 3)));
      drive(w, 1'b1);
    end
    idle(1);
    check_pulses(tag, EV_NONE);
    chk({tag, "_busy"}, PW'(busy), PW'(0));
  endtask

  initial begin
    int kind;
    rst = 1'b1; din = '0; din_valid = 1'b0;
    exp_cmd = '0; exp_len = '0; exp_payload = '0;
    repeat (3) @(negedge clk);
    check_outputs("reset");
    check_pulses("reset", EV_NONE);
    chk("reset_busy", PW'(busy), PW'(0));
    rst = 1'b0;

    // Two-word payload frame
    frame_q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_frame(1'b0);
    finish_frame("t1");
    chk("t1_payload_lo", PW'(payload_out[15:0]), PW'(16'h2211));
    chk("t1_payload_hi", PW'(payload_out[PW-1:16]), PW'(0));

    // Zero-length frame
    frame_q = '{8'hA5, 8'h07, 8'h00, 8'h07};
    send_frame(1'b1);
    finish_frame("t2");

    // Bad checksum leaves the previous outputs in place
    frame_q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hFF};
    send_frame(1'b0);
    finish_frame("t3");
    chk("t3_cmd_held", PW'(cmd_out), PW'(8'h07));

    // Oversize length, then a good frame
    frame_q = '{8'hA5, 8'h10, 8'h09};
    send_frame(1'b0);
    finish_frame("t4");
    build_good(8'h3C, 3);
    send_frame(1'b1);
    finish_frame("t4_good");

    // Inter-word timeout
    drive(8'hA5, 1'b1);
    drive(8'h10, 1'b1);
    idle(int'(T) + 1);
    exp_n_tmo++;
    check_pulses("t5", EV_TMO);
    chk("t5_busy", PW'(busy), PW'(0));

    // Word on the expiry cycle continues the frame
    frame_q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    drive(8'hA5, 1'b1);
    drive(8'h10, 1'b1);
    idle(int'(T) - 1);
    drive(8'h02, 1'b1);
    drive(8'h11, 1'b1);
    drive(8'h22, 1'b1);
    drive(8'h21, 1'b1);
    finish_frame("t5v");

    // Reset mid-payload discards the partial frame silently
    frame_q = '{8'hA5, 8'h44, 8'h04, 8'hAA, 8'hBB};
    send_frame(1'b0);
    @(negedge clk); rst = 1'b1; din_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    exp_cmd = '0; exp_len = '0; exp_payload = '0;
    check_outputs("t6_rst");
    check_pulses("t6_rst", EV_NONE);
    chk("t6_rst_busy", PW'(busy), PW'(0));
    drive(8'h00, 1'b1);
    drive(8'hFF, 1'b1);
    frame_q = '{8'hA5, 8'h01, 8'h01, 8'h55, 8'h55};
    send_frame(1'b0);
    finish_frame("t6");
    chk("t6_word0", PW'(payload_out[7:0]), PW'(8'h55));

    // Randomized mix of frame types
    for (int n = 0; n < 80; n++) begin
      idle(int'($urandom_range(0, 5)));
      kind = int'($urandom_range(0, 9));
      case (kind)
        5: begin
          build_good(8'($urandom), int'($urandom_range(0, MP)));
          frame_q[frame_q.size() - 1] = frame_q[frame_q.size() - 1] ^ 8'($urandom_range(1, 255));
          send_frame(1'b1);
          finish_frame("rnd_badcs");
        end
        6: begin
          frame_q = '{8'hA5, 8'($urandom), 8'($urandom_range(MP + 1, 255))};
          send_frame(1'b1);
          finish_frame("rnd_len");
        end
        7: do_timeout("rnd_tmo");
        8: do_junk("rnd_junk");
        9: begin
          build_good(8'($urandom), int'($urandom_range(0, MP)));
          send_frame(1'b0);
          finish_frame("rnd_b2b");
        end
        default: begin
          build_good(8'($urandom), int'($urandom_range(0, MP)));
          send_frame(1'b1);
          finish_frame("rnd_good");
        end
      endcase
    end

    idle(2);
    chk("total_cmd_valid", PW'(obs_n_valid), PW'(exp_n_valid));
    chk("total_err_csum",  PW'(obs_n_csum),  PW'(exp_n_csum));
    chk("total_err_len",   PW'(obs_n_len),   PW'(exp_n_len));
    chk("total_err_tmo",   PW'(obs_n_tmo),   PW'(exp_n_tmo));
    chk("pulse_overlap",   PW'(obs_overlap), PW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
